// File: rtl/shift_reg_serial_loader.sv
// Serial MSB-first parallel-word loader with single-step right shifts and synchronous clear.
module shift_reg_serial_loader #(
    parameter int unsigned x = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         shift_en,
    input  logic         extend,
    input  logic         load,
    input  logic [x-1:0] data_in,
    output logic [x-1:0] q
);

    localparam int unsigned CW = $clog2(x + 1);

    logic [x-1:0]  hold_r;
    logic [x-1:0]  hold_nxt;
    logic [x-1:0]  q_nxt;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_nxt;
    logic          active_c;
    logic          ser_bit_c;
    logic          fill_c;

    assign active_c = (cnt_r != '0);
    assign fill_c   = extend ? q[x-1] : 1'b0;

    // Select hold[cnt-1], the next bit to enter q; loop avoids a variable-width index.
    always_comb begin
        ser_bit_c = 1'b0;
        for (int unsigned i = 0; i < x; i++) begin
            if (cnt_r == CW'(i + 1)) begin
                ser_bit_c = hold_r[i];
            end
        end
    end

    // Next-state selection in priority order: clr, load, serial step, shift, hold.
    always_comb begin
        hold_nxt = hold_r;
        q_nxt    = q;
        cnt_nxt  = cnt_r;
        if (clr) begin
            q_nxt   = '0;
            cnt_nxt = '0;
        end else if (load) begin
            hold_nxt = data_in;
            q_nxt    = '0;
            cnt_nxt  = CW'(x);
        end else if (active_c) begin
            q_nxt   = {q[x-2:0], ser_bit_c};
            cnt_nxt = cnt_r - CW'(1);
        end else if (shift_en) begin
            q_nxt = {fill_c, q[x-1:1]};
        end
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            q      <= '0;
            hold_r <= '0;
            cnt_r  <= '0;
        end else begin
            q      <= q_nxt;
            hold_r <= hold_nxt;
            cnt_r  <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_shift_reg_serial_loader.sv
// Scoreboard bench: stimulus pushes the expected q per edge, a monitor pops and compares.
module tb_shift_reg_serial_loader;

    localparam int unsigned W = 5;

    typedef struct {
        logic [W-1:0] exp;
        string        name;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst, clr, shift_en, extend, load;
    logic [W-1:0] data_in;
    logic [W-1:0] q;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    shift_reg_serial_loader #(.x(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .shift_en (shift_en),
        .extend   (extend),
        .load     (load),
        .data_in  (data_in),
        .q        (q)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs at the falling edge and queue q expected after the next rising edge.
    task automatic cyc(input logic r, input logic c, input logic l, input logic se,
                       input logic ex, input logic [W-1:0] d, input logic [W-1:0] e,
                       input string nm);
        exp_t item;
        @(negedge clk);
        rst      = r;
        clr      = c;
        load     = l;
        shift_en = se;
        extend   = ex;
        data_in  = d;
        item.exp  = e;
        item.name = nm;
        sb_q.push_back(item);
    endtask

    task automatic idle(input logic [W-1:0] e, input string nm);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, data_in, e, nm);
    endtask

    // Monitor: after each rising edge compare q with the oldest queued expectation.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() != 0) begin
                exp_t item;
                item = sb_q.pop_front();
                n_checks++;
                if (q !== item.exp) begin
                    n_fail++;
                    $display("FAIL %s: q=%b expected=%b at %0t", item.name, q, item.exp, $time);
                end
            end
        end
    end

    initial begin
        rst = 1'b1; clr = 1'b0; shift_en = 1'b0; extend = 1'b0; load = 1'b0; data_in = '0;

        // Reset and basic load of 10101
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'b00000, 5'b00000, "reset");
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'b10101, 5'b00000, "load_a_edge");
        idle(5'b00001, "load_a_1");
        idle(5'b00010, "load_a_2");
        idle(5'b00101, "load_a_3");
        idle(5'b01010, "load_a_4");
        idle(5'b10101, "load_a_5");
        idle(5'b10101, "load_a_hold1");
        idle(5'b10101, "load_a_hold2");

        // Asymmetric word, MSB first
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'b11000, 5'b00000, "load_b_edge");
        idle(5'b00001, "load_b_1");
        idle(5'b00011, "load_b_2");
        idle(5'b00110, "load_b_3");
        idle(5'b01100, "load_b_4");
        idle(5'b11000, "load_b_5");

        // Logical shift from 10110
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'b10110, 5'b00000, "load_c_edge");
        idle(5'b00001, "load_c_1");
        idle(5'b00010, "load_c_2");
        idle(5'b00101, "load_c_3");
        idle(5'b01011, "load_c_4");
        idle(5'b10110, "load_c_5");
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'b10110, 5'b01011, "shift_logical");
        idle(5'b01011, "shift_hold");

        // Arithmetic shifts from 10110
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'b10110, 5'b00000, "load_d_edge");
        idle(5'b00001, "load_d_1");
        idle(5'b00010, "load_d_2");
        idle(5'b00101, "load_d_3");
        idle(5'b01011, "load_d_4");
        idle(5'b10110, "load_d_5");
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'b10110, 5'b11011, "shift_arith_1");
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'b10110, 5'b11101, "shift_arith_2");

        // Clear on the third shift edge of a load
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'b10101, 5'b00000, "load_e_edge");
        idle(5'b00001, "load_e_1");
        idle(5'b00010, "load_e_2");
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'b10101, 5'b00000, "clr_mid_load");
        for (int i = 0; i < 5; i++) idle(5'b00000, "clr_stays_zero");

        // Reload mid-load, shift_en ignored while active
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'b11111, 5'b00000, "load_f_edge");
        idle(5'b00001, "load_f_1");
        idle(5'b00011, "load_f_2");
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'b00001, 5'b00000, "reload_edge");
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'b00001, 5'b00000, "reload_1_shift_ign");
        idle(5'b00000, "reload_2");
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'b00001, 5'b00000, "reload_3_shift_ign");
        idle(5'b00000, "reload_4");
        idle(5'b00001, "reload_5");
        idle(5'b00001, "reload_hold");

        // Load held high keeps q at zero
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'b11111, 5'b00000, "load_held_1");
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'b11111, 5'b00000, "load_held_2");
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'b11111, 5'b00000, "load_held_3");
        idle(5'b00001, "load_held_rel_1");

        // Reset mid-load
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'b10101, 5'b00000, "load_g_edge");
        idle(5'b00001, "load_g_1");
        idle(5'b00010, "load_g_2");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'b10101, 5'b00000, "rst_mid_load");
        idle(5'b00000, "rst_idle_1");
        idle(5'b00000, "rst_idle_2");

        // data_in changes after capture are ignored
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'b11000, 5'b00000, "load_h_edge");
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b00111, 5'b00001, "load_h_1");
        idle(5'b00011, "load_h_2");
        idle(5'b00110, "load_h_3");
        idle(5'b01100, "load_h_4");
        idle(5'b11000, "load_h_5");
        idle(5'b11000, "load_h_hold");

        // Let the monitor drain, bounded
        repeat (3) @(posedge clk);
        #2;
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: pending=%0d expected=0", sb_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/shift_reg_serial_loader.md
Name: shift_reg_serial_loader

Overview:
- Parameterised x-bit register that loads a parallel word serially, one bit per clock, MSB first.
- A one-cycle `load` pulse captures `data_in`, clears `q`, then shifts the captured bits into `q` over the next x clocks.
- Also supports single-step right shifts (logical or arithmetic) and a synchronous clear.
- Used as a datapath register where the shift-in progression of a word must be visible cycle by cycle.

Parameters:
- x, default 5, register width in bits (x >= 2).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- clr  input  1  synchronous clear of `q`; aborts any serial load in progress.
- shift_en  input  1  single-step right shift of `q`; honoured only when no serial load is active.
- extend  input  1  fill-bit select for `shift_en`: 1 = arithmetic (replicate `q[x-1]`), 0 = logical (insert 0).
- load  input  1  start a serial load of `data_in`; sampled at a rising edge.
- data_in  input  x  parallel word to be loaded serially.
- q  output  x  register contents (registered output).

Behaviour:
- Reset is synchronous, active-high, on `clk` (fixed decision). Reset value:
  - `q` = 0.
  - Internal holding register = 0.
  - Bit counter = 0.
  - Loader idle.
- Internal state:
  - hold[x-1:0]: captured word.
  - cnt: bits remaining, range 0..x.
  - active flag = (cnt != 0).
- Priority at each rising edge: rst > clr > load > active serial step > shift_en > hold.
- clr: `q` <= 0, cnt <= 0 (loader aborted); hold unchanged.
- load = 1 (edge L0): hold <= `data_in`, `q` <= 0, cnt <= x. `data_in` is only sampled at this edge; later changes are ignored.
- Active serial step (cnt = k > 0, load = 0): `q` <= {`q`[x-2:0], hold[k-1]}, cnt <= k-1.
  - Bits enter at `q[0]`, MSB of hold first.
  - After edge L0+n (1 <= n <= x), `q` equals the top n bits of hold, right-aligned.
  - After edge L0+x, `q` == hold, cnt = 0, and `q` holds.
- Latency: `q` == `data_in` (as captured) exactly x clocks after the load edge; first bit visible 1 clock after the load edge.
- Load asserted during an active load: restarts — recapture, clear `q`, cnt <= x.
- Load held high for several cycles: restarts every cycle, so `q` stays 0 until load deasserts.
- shift_en while active: ignored; the serial step proceeds.
- shift_en while idle: `q` <= {fill, `q`[x-1:1]}, fill = extend ? `q`[x-1] : 0. Applies every cycle it is high.
- extend has no effect unless shift_en is acting.
- No wrap-around: cnt saturates at 0; idle with no controls asserted holds `q`.
- rst or clr mid-load: `q` = 0 next cycle, loader idle; no further bits shift in.

Test Plan:
- Reset then basic load, x=5: rst for 1 edge; `data_in`=10101, load pulse 1 cycle -> `q`=00000 after load edge, then 00001, 00010, 00101, 01010, 10101 on successive edges; holds 10101 thereafter.
- Asymmetric word (verifies MSB-first): `data_in`=11000 -> `q` 00000, 00001, 00011, 00110, 01100, 11000.
- Right shifts from idle with `q`=10110: shift_en with extend=0 -> 01011. Reload to 10110, then shift_en with extend=1 -> 11011, then 11101.
- Clear mid-load: clr on the third shift edge of a 10101 load -> `q`=00000; stays 0 for the following 5 cycles.
- Reload mid-load: load 11111, after 2 bits (00011) pulse load with 00001 -> `q` 00000, 00000, 00000, 00000, 00000, 00001; shift_en pulses asserted during the load are ignored.
- Reset mid-load and `data_in` change after capture: rst during a load -> `q`=0 and idle. In a separate load, changing `data_in` after the load edge does not alter the final `q`.
